// File: rtl/hann_frame_scheduler.sv
// Buffers an input sample stream in a FRAME_LEN-deep ring and replays it as
// overlapping frames (advance HOP_LEN) for a downstream Hann window stage.
module hann_frame_scheduler #(
    parameter  int I_BW       = 14,
    parameter  int FRAME_LEN  = 1024,
    parameter  int HOP_LEN    = 512,
    parameter  int TOTAL_DATA = 91136,
    localparam int NUM_FRAMES = (TOTAL_DATA - FRAME_LEN) / HOP_LEN + 1,
    localparam int AW         = $clog2(FRAME_LEN),
    localparam int FW         = $clog2(NUM_FRAMES) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [I_BW-1:0] data_i,
    input  logic                   di_en,
    output logic                   di_rdy,
    output logic signed [I_BW-1:0] data_o,
    output logic                   do_en,
    output logic [AW-1:0]          sample_idx,
    output logic [FW-1:0]          frame_num,
    output logic                   frame_last,
    output logic                   done
);

    localparam int CW = $clog2(TOTAL_DATA + FRAME_LEN + 1);
    localparam int OW = AW + 1;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_EMIT = 2'd1,
        ST_NEXT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]     fb_q, fb_d;
    logic [OW-1:0]     occ_q, occ_d;
    logic [AW-1:0]     rd_idx_q, rd_idx_d;
    logic [FW-1:0]     frame_num_q, frame_num_d;
    logic [I_BW-1:0]   data_o_q, data_o_d;
    logic [AW-1:0]     sample_idx_q, sample_idx_d;
    logic              do_en_q, do_en_d;
    logic              frame_last_q, frame_last_d;
    logic              done_q, done_d;
    logic              di_rdy_q, di_rdy_d;

    logic              wr_en_s;
    logic              rd_en_s;
    logic              rel_s;
    logic [AW-1:0]     rd_addr_s;
    logic [I_BW-1:0]   mem [FRAME_LEN];

    // Next-state, occupancy bookkeeping and output staging.
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        fb_d         = fb_q;
        occ_d        = occ_q;
        rd_idx_d     = rd_idx_q;
        frame_num_d  = frame_num_q;
        done_d       = done_q;
        rd_en_s      = 1'b0;
        rel_s        = 1'b0;
        wr_en_s      = di_en & di_rdy_q;
        rd_addr_s    = fb_q[AW-1:0] + rd_idx_q;

        case (state_q)
            ST_WAIT: begin
                if (wr_cnt_q >= fb_q + CW'(FRAME_LEN)) begin
                    state_d  = ST_EMIT;
                    rd_idx_d = '0;
                end else begin
                    state_d  = ST_WAIT;
                end
            end
            ST_EMIT: begin
                rd_en_s  = 1'b1;
                // Only the first HOP_LEN samples leave the window for good.
                rel_s    = ({1'b0, rd_idx_q} < OW'(HOP_LEN));
                rd_idx_d = rd_idx_q + AW'(1);
                if (rd_idx_q == AW'(FRAME_LEN - 1)) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_NEXT: begin
                fb_d        = fb_q + CW'(HOP_LEN);
                frame_num_d = frame_num_q + FW'(1);
                if (frame_num_q == FW'(NUM_FRAMES - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase

        if (wr_en_s) begin
            wr_cnt_d = wr_cnt_q + CW'(1);
        end else begin
            wr_cnt_d = wr_cnt_q;
        end

        // A same-cycle write is qualified by the pre-release occupancy.
        case ({wr_en_s, rel_s})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase

        do_en_d      = rd_en_s;
        data_o_d     = rd_en_s ? mem[rd_addr_s] : '0;
        sample_idx_d = rd_en_s ? rd_idx_q : '0;
        frame_last_d = rd_en_s & (rd_idx_q == AW'(FRAME_LEN - 1));
        di_rdy_d     = (occ_d < OW'(FRAME_LEN)) & (wr_cnt_d < CW'(TOTAL_DATA)) & ~done_d;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_WAIT;
            wr_cnt_q     <= '0;
            fb_q         <= '0;
            occ_q        <= '0;
            rd_idx_q     <= '0;
            frame_num_q  <= '0;
            data_o_q     <= '0;
            sample_idx_q <= '0;
            do_en_q      <= 1'b0;
            frame_last_q <= 1'b0;
            done_q       <= 1'b0;
            di_rdy_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            fb_q         <= fb_d;
            occ_q        <= occ_d;
            rd_idx_q     <= rd_idx_d;
            frame_num_q  <= frame_num_d;
            data_o_q     <= data_o_d;
            sample_idx_q <= sample_idx_d;
            do_en_q      <= do_en_d;
            frame_last_q <= frame_last_d;
            done_q       <= done_d;
            di_rdy_q     <= di_rdy_d;
        end
    end

    // Ring buffer storage; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_cnt_q[AW-1:0]] <= data_i;
        end
    end

    assign di_rdy     = di_rdy_q;
    assign data_o     = data_o_q;
    assign do_en      = do_en_q;
    assign sample_idx = sample_idx_q;
    assign frame_num  = frame_num_q;
    assign frame_last = frame_last_q;
    assign done       = done_q;

endmodule
